// File: rtl/reg_writeback_queue.sv
// Register writeback queue: buffers producer writes, drains them one per cycle
// into registered wb_* outputs. Define WBQ_BYPASS_EN to build the lk_* bypass lookup.
module reg_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               in_dest,
   input  logic [31:0]              in_val,
   input  logic                     hold,
   output logic                     wb_en,
   output logic [4:0]               wb_dest,
   output logic [31:0]              wb_val,
   input  logic [4:0]               lk_src,
   output logic                     lk_hit,
   output logic [31:0]              lk_val,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    dest_mem_q [DEPTH];
   logic [31:0]   val_mem_q  [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wb_en_q, wb_en_d;
   logic [4:0]    wb_dest_q, wb_dest_d;
   logic [31:0]   wb_val_q, wb_val_d;
   logic          push_s, pop_s;

   // in_ready looks only at the stored count, never at this cycle's pop
   assign in_ready = (count_q < CW'(DEPTH));
   assign push_s   = in_valid && in_ready && (in_dest != 5'd0);
   assign pop_s    = (count_q != CW'(0)) && !hold;

   assign count    = count_q;
   assign wb_en    = wb_en_q;
   assign wb_dest  = wb_dest_q;
   assign wb_val   = wb_val_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      wb_en_d   = 1'b0;
      wb_dest_d = wb_dest_q;
      wb_val_d  = wb_val_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         wb_en_d   = 1'b1;
         wb_dest_d = dest_mem_q[rd_ptr_q];
         wb_val_d  = val_mem_q[rd_ptr_q];
      end else begin
         rd_ptr_d  = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wb_en_q   <= 1'b0;
         wb_dest_q <= 5'd0;
         wb_val_q  <= 32'd0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         wb_en_q   <= wb_en_d;
         wb_dest_q <= wb_dest_d;
         wb_val_q  <= wb_val_d;
      end
   end

   // Storage is pure datapath; validity is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (push_s) begin
         dest_mem_q[wr_ptr_q] <= in_dest;
         val_mem_q[wr_ptr_q]  <= in_val;
      end
   end

`ifdef WBQ_BYPASS_EN
   logic [AW-1:0] lk_idx_s;
   logic          lk_match_s;

   // Scan oldest to youngest so later matches overwrite earlier ones
   always_comb begin
      lk_hit     = 1'b0;
      lk_val     = 32'd0;
      lk_idx_s   = '0;
      lk_match_s = 1'b0;
      if (lk_src != 5'd0) begin
         if (wb_en_q && (wb_dest_q == lk_src)) begin
            lk_hit = 1'b1;
            lk_val = wb_val_q;
         end else begin
            lk_hit = 1'b0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            lk_idx_s   = rd_ptr_q + AW'(i);
            lk_match_s = (CW'(i) < count_q) && (dest_mem_q[lk_idx_s] == lk_src);
            lk_hit     = lk_match_s ? 1'b1 : lk_hit;
            lk_val     = lk_match_s ? val_mem_q[lk_idx_s] : lk_val;
         end
      end else begin
         lk_hit = 1'b0;
         lk_val = 32'd0;
      end
   end
`else
   logic unused_lk_s;
   assign unused_lk_s = ^lk_src;
   assign lk_hit      = 1'b0;
   assign lk_val      = 32'd0;
`endif

endmodule
